// File: rtl/reg_bank_dump_reader.sv
// Streams a wrapping address range of a flat register bank out over a valid/ready port.
// Optional running checksum of accepted words is enabled by defining DUMP_CHECKSUM_EN.
module reg_bank_dump_reader #(
    parameter int DATA_LENGTH = 32,
    parameter int REGS_QTY    = 32,
    localparam int ADDR_LENGTH = $clog2(REGS_QTY)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [DATA_LENGTH*REGS_QTY-1:0] q_bank,
    input  logic                            start,
    input  logic [ADDR_LENGTH-1:0]          start_addr,
    input  logic [ADDR_LENGTH-1:0]          end_addr,
    input  logic                            abort,
    input  logic                            out_ready,
    output logic                            out_valid,
    output logic [DATA_LENGTH-1:0]          out_data,
    output logic [ADDR_LENGTH-1:0]          out_addr,
    output logic                            busy,
    output logic                            done,
    output logic [DATA_LENGTH-1:0]          checksum
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SEND = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]             state_r;
    logic [ADDR_LENGTH-1:0] end_addr_r;
    logic [ADDR_LENGTH-1:0] next_addr_s;
    logic [ADDR_LENGTH-1:0] cap_addr_s;
    logic [DATA_LENGTH-1:0] cap_word_s;
    logic                   accept_s;

    function automatic logic [DATA_LENGTH-1:0] bank_word(
        input logic [DATA_LENGTH*REGS_QTY-1:0] bank,
        input logic [ADDR_LENGTH-1:0]          idx
    );
        return bank[idx*DATA_LENGTH +: DATA_LENGTH];
    endfunction

    // Increment wraps naturally because REGS_QTY is a power of two.
    assign next_addr_s = out_addr + {{(ADDR_LENGTH-1){1'b0}}, 1'b1};
    assign cap_word_s  = bank_word(q_bank, cap_addr_s);
    assign accept_s    = (state_r == ST_SEND) && out_valid && out_ready && !abort;

    // Select which register index is snapshotted on the next capture edge.
    always_comb begin
        cap_addr_s = next_addr_s;
        if (state_r == ST_IDLE) begin
            cap_addr_s = start_addr;
        end else begin
            cap_addr_s = next_addr_s;
        end
    end

    // Dump sequencer: IDLE -> SEND (one word per handshake) -> DONE pulse -> IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            end_addr_r <= {ADDR_LENGTH{1'b0}};
            out_valid  <= 1'b0;
            out_data   <= {DATA_LENGTH{1'b0}};
            out_addr   <= {ADDR_LENGTH{1'b0}};
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state_r    <= ST_SEND;
                        end_addr_r <= end_addr;
                        out_addr   <= start_addr;
                        out_data   <= cap_word_s;
                        out_valid  <= 1'b1;
                        busy       <= 1'b1;
                    end
                end
                ST_SEND: begin
                    if (abort) begin
                        state_r   <= ST_IDLE;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                    end else if (out_valid && out_ready) begin
                        if (out_addr == end_addr_r) begin
                            state_r   <= ST_DONE;
                            out_valid <= 1'b0;
                            done      <= 1'b1;
                        end else begin
                            out_addr <= next_addr_s;
                            out_data <= cap_word_s;
                        end
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                    done    <= 1'b0;
                    busy    <= 1'b0;
                end
                default: begin
                    state_r   <= ST_IDLE;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                end
            endcase
        end
    end

`ifdef DUMP_CHECKSUM_EN
    logic [DATA_LENGTH-1:0] checksum_r;

    // Running sum of accepted words, restarted by each accepted start.
    always_ff @(posedge clk) begin
        if (rst) begin
            checksum_r <= {DATA_LENGTH{1'b0}};
        end else if ((state_r == ST_IDLE) && start) begin
            checksum_r <= {DATA_LENGTH{1'b0}};
        end else if (accept_s) begin
            checksum_r <= checksum_r + out_data;
        end
    end

    assign checksum = checksum_r;
`else
    logic unused_accept_s;
    assign unused_accept_s = accept_s;
    assign checksum        = {DATA_LENGTH{1'b0}};
`endif

endmodule
